// File: rtl/bk_pkg.sv
// Shared definitions for the BK-family sequencers that wrap the 16-bit
// Brent-Kung adder: the slice width and the common three-state FSM type.
package bk_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bk_multiword_add_seq_bk_adder.sv
// BK_Adder: combinational 16-bit Brent-Kung parallel-prefix adder.
// Ports:
//   s    out 16  sum a + b + cin (mod 2^16)
//   cout out 1   carry out of bit 15
//   a    in  16  operand A
//   b    in  16  operand B
//   cin  in  1   carry in
module BK_Adder (
  output logic [15:0] s,
  output logic        cout,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin
);

  logic [15:0] p;
  logic [15:0] gg;   // group generate, ends as prefix G[0..i]
  logic [15:0] pp;   // group propagate matching gg
  logic [16:0] c;

  assign p = a ^ b;

  // The prefix tree is evaluated in place. Within one level the nodes that
  // are written are never read, so the in-place update equals a layered net.
  always_comb begin
    pp = p;
    gg = a & b;
    // Fold cin into bit 0 so every gg[i] becomes the true carry into bit i+1.
    gg[0] = gg[0] | (p[0] & cin);

    // Up-sweep: nodes 2^(l+1)-1 (mod 2^(l+1)) absorb the span below them.
    for (int l = 0; l < 4; l++) begin
      for (int i = (2 << l) - 1; i < 16; i += (2 << l)) begin
        gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
        pp[i] = pp[i] & pp[i - (1 << l)];
      end
    end

    // Down-sweep: fill the remaining nodes from the completed spans.
    for (int l = 2; l >= 0; l--) begin
      for (int i = (3 << l) - 1; i < 16; i += (2 << l)) begin
        gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
        pp[i] = pp[i] & pp[i - (1 << l)];
      end
    end
  end

  assign c    = {gg, cin};
  assign s    = p ^ c[15:0];
  assign cout = c[16];

endmodule

// File: rtl/bk_multiword_add_seq.sv
// bk_multiword_add_seq: adds or subtracts two WORDS*16-bit operands one
// 16-bit slice per clock (LSB slice first) through a single BK_Adder, with
// the carry registered between slices.
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready high only in IDLE)
//   in_a, in_b          W-bit operands
//   in_cin              carry-in for add mode
//   in_sub              1: A-B, 0: A+B+cin
//   out_valid/out_ready result handshake
//   out_sum             W-bit result
//   out_cout            carry out of MSB (sub: 1 = no borrow)
//   out_ovf             two's-complement overflow
//   busy                high in RUN or DONE
module bk_multiword_add_seq
  import bk_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SLICE_W*WORDS-1:0] in_a,
  input  logic [SLICE_W*WORDS-1:0] in_b,
  input  logic                   in_cin,
  input  logic                   in_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SLICE_W*WORDS-1:0] out_sum,
  output logic                   out_cout,
  output logic                   out_ovf,
  output logic                   busy
);

  localparam int W     = SLICE_W * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t             state;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;     // already inverted in subtract mode
  logic               carry;
  logic [IDX_W-1:0]   idx;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_cout;

  assign slice_a = a_q[SLICE_W*idx +: SLICE_W];
  assign slice_b = b_q[SLICE_W*idx +: SLICE_W];

  BK_Adder u_bk_adder (
    .s    (slice_s),
    .cout (slice_cout),
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry)
  );

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // NOTE: every register here uses <= so all of them update together from
  // the values present before the edge; blocking = would let later lines
  // see half-updated state and break the slice/carry pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_sub ? ~in_b : in_b;
            carry   <= in_sub ? 1'b1 : in_cin;
            idx     <= '0;
            out_sum <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          out_sum[SLICE_W*idx +: SLICE_W] <= slice_s;
          carry <= slice_cout;
          if (idx == LAST_IDX) begin
            out_cout  <= slice_cout;
            // Carry into the MSB is recovered from the final slice's sum bit.
            out_ovf   <= slice_s[SLICE_W-1] ^ slice_a[SLICE_W-1]
                       ^ slice_b[SLICE_W-1] ^ slice_cout;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bk_multiword_add_seq.sv
// Self-checking bench for bk_multiword_add_seq: directed corner cases on a
// WORDS=4 and a WORDS=1 instance, then randomized add/sub traffic with
// back-to-back and stalled handshakes against an arithmetic reference.
module tb_bk_multiword_add_seq;

  logic        clk = 1'b0;
  logic        rst_n;

  // WORDS=4 instance
  logic        in_valid, in_ready, in_cin, in_sub;
  logic [63:0] in_a, in_b, out_sum;
  logic        out_valid, out_ready, out_cout, out_ovf, busy;

  // WORDS=1 instance
  logic        in_valid1, in_ready1, in_cin1, in_sub1;
  logic [15:0] in_a1, in_b1, out_sum1;
  logic        out_valid1, out_ready1, out_cout1, out_ovf1, busy1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bk_multiword_add_seq #(.WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .busy(busy)
  );

  bk_multiword_add_seq #(.WORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_cin(in_cin1), .in_sub(in_sub1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_sum(out_sum1), .out_cout(out_cout1), .out_ovf(out_ovf1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 65-bit arithmetic; overflow from operand/result signs.
  function automatic logic [65:0] ref_op(input logic [63:0] a, input logic [63:0] b,
                                         input logic cin, input logic sub);
    logic [64:0] full;
    logic        ovf;
    if (sub) begin
      full = {1'b0, a} - {1'b0, b};
      full[64] = (a >= b);          // carry out = no borrow
      ovf = (a[63] != b[63]) && (full[63] != a[63]);
    end else begin
      full = {1'b0, a} + {1'b0, b} + {64'd0, cin};
      ovf = (a[63] == b[63]) && (full[63] != a[63]);
    end
    return {ovf, full};
  endfunction

  // One full transaction on the WORDS=4 instance. 'noise' keeps in_valid
  // high with other operands while busy, which must be ignored.
  task automatic run4(input logic [63:0] a, input logic [63:0] b, input logic cin,
                      input logic sub, input int stall, input logic noise,
                      output logic [63:0] sum, output logic cout, output logic ovf,
                      output int lat);
    int guard;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    out_ready = 1'b0;
    guard = 0;
    while (!in_ready && guard < 20) begin step(); guard++; end
    if (guard >= 20) check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    step();  // accept edge
    in_valid = noise;
    if (noise) begin
      in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; in_sub = 1'($urandom);
    end
    lat = 0;
    while (!out_valid && lat < 50) begin step(); lat++; end
    sum = out_sum; cout = out_cout; ovf = out_ovf;
    for (int i = 0; i < stall; i++) begin
      step();
      check("stall_in_ready", {63'd0, in_ready}, 64'd0);
      check("stall_valid",    {63'd0, out_valid}, 64'd1);
    end
    if (stall > 0) begin
      check("hold_sum",  out_sum, sum);
      check("hold_cout", {63'd0, out_cout}, {63'd0, cout});
      check("hold_ovf",  {63'd0, out_ovf}, {63'd0, ovf});
    end
    out_ready = 1'b1;
    step();  // result handshake edge
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    logic [63:0] sum, a, b;
    logic        cout, ovf, cin, sub;
    logic [65:0] exp;
    int          lat, stall;

    rst_n = 1'b0;
    in_valid = 0; in_a = '0; in_b = '0; in_cin = 0; in_sub = 0; out_ready = 0;
    in_valid1 = 0; in_a1 = '0; in_b1 = '0; in_cin1 = 0; in_sub1 = 0; out_ready1 = 0;
    step(); step();

    // Reset state
    check("rst_in_ready",  {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_sum",       out_sum, 64'd0);
    check("rst_cout",      {63'd0, out_cout}, 64'd0);
    check("rst_ovf",       {63'd0, out_ovf}, 64'd0);
    check("rst_busy",      {63'd0, busy}, 64'd0);
    rst_n = 1'b1;

    // 1: carry ripples through every slice
    run4(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0, 1'b0, sum, cout, ovf, lat);
    check("t1_sum", sum, 64'd0);
    check("t1_cout", {63'd0, cout}, 64'd1);
    check("t1_ovf", {63'd0, ovf}, 64'd0);
    check("t1_latency", 64'(lat), 64'd4);
    check("t1_idle_after", {63'd0, in_ready}, 64'd1);
    check("t1_valid_fell", {63'd0, out_valid}, 64'd0);

    // 2: borrow across a slice boundary
    run4(64'h0000_0000_0001_0000, 64'd1, 1'b0, 1'b1, 0, 1'b0, sum, cout, ovf, lat);
    check("t2_sum", sum, 64'h0000_0000_0000_FFFF);
    check("t2_cout", {63'd0, cout}, 64'd1);
    check("t2_ovf", {63'd0, ovf}, 64'd0);

    // 3: signed overflow
    run4(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0, 1'b0, sum, cout, ovf, lat);
    check("t3_sum", sum, 64'h8000_0000_0000_0000);
    check("t3_cout", {63'd0, cout}, 64'd0);
    check("t3_ovf", {63'd0, ovf}, 64'd1);

    // 4: 10-cycle backpressure with a competing in_valid
    run4(64'h1111_2222_3333_4444, 64'h0101_0202_0303_0404, 1'b1, 1'b0, 10, 1'b1,
         sum, cout, ovf, lat);
    check("t4_sum", sum, 64'h1212_2424_3636_4849);
    check("t4_idle_after", {63'd0, in_ready}, 64'd1);
    check("t4_valid_fell", {63'd0, out_valid}, 64'd0);
    check("t4_not_busy", {63'd0, busy}, 64'd0);

    // 5: reset while idx=2
    in_a = 64'hAAAA_BBBB_CCCC_DDDD; in_b = 64'h1; in_cin = 0; in_sub = 0; in_valid = 1;
    step();  // accept; idx=0
    in_valid = 0;
    step(); step();  // idx=2
    check("t5_busy_mid", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t5_in_ready", {63'd0, in_ready}, 64'd1);
    check("t5_out_valid", {63'd0, out_valid}, 64'd0);
    check("t5_sum", out_sum, 64'd0);
    check("t5_busy", {63'd0, busy}, 64'd0);
    run4(64'h1234, 64'd1, 1'b0, 1'b0, 0, 1'b0, sum, cout, ovf, lat);
    check("t5_follow_sum", sum, 64'h1235);

    // 6: WORDS=1 instance
    in_a1 = 16'h8000; in_b1 = 16'h8000; in_cin1 = 0; in_sub1 = 0; in_valid1 = 1;
    step();
    in_valid1 = 0;
    lat = 0;
    while (!out_valid1 && lat < 20) begin step(); lat++; end
    check("t6_latency", 64'(lat), 64'd1);
    check("t6_sum", {48'd0, out_sum1}, 64'd0);
    check("t6_cout", {63'd0, out_cout1}, 64'd1);
    check("t6_ovf", {63'd0, out_ovf1}, 64'd1);
    out_ready1 = 1;
    step();
    out_ready1 = 0;
    check("t6_idle_after", {63'd0, in_ready1}, 64'd1);

    // Random traffic
    for (int n = 0; n < 10000; n++) begin
      case ($urandom_range(0, 5))
        0:       a = 64'hFFFF_FFFF_FFFF_FFFF;
        1:       a = 64'h7FFF_FFFF_FFFF_FFFF;
        2:       a = 64'h8000_0000_0000_0000;
        default: a = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 5))
        0:       b = 64'd1;
        1:       b = 64'h8000_0000_0000_0000;
        2:       b = 64'd0;
        default: b = {$urandom, $urandom};
      endcase
      cin   = 1'($urandom);
      sub   = 1'($urandom);
      stall = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      if ($urandom_range(0, 15) == 0) step();  // occasional idle gap
      run4(a, b, cin, sub, stall, 1'($urandom), sum, cout, ovf, lat);
      exp = ref_op(a, b, cin, sub);
      check("rnd_sum", sum, exp[63:0]);
      check("rnd_cout", {63'd0, cout}, {63'd0, exp[64]});
      check("rnd_ovf", {63'd0, ovf}, {63'd0, exp[65]});
      check("rnd_latency", 64'(lat), 64'd4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
